// File: rtl/ring_gate_pkg.sv
// ring_gate_pkg: shared types and helpers for the ring-gate reducer.
package ring_gate_pkg;
  typedef enum logic [1:0] {MODE_OR = 2'b00, MODE_AND = 2'b01, MODE_XOR = 2'b10} mode_e;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;
  typedef enum logic [1:0] {K_AND, K_NOT, K_OR} kind_e;
  function automatic kind_e term_kind(input int i);
    return (i % 3 == 0) ? K_AND : (i % 3 == 1) ? K_NOT : K_OR;
  endfunction
  function automatic logic mode_identity(input logic [1:0] m);
    return m == MODE_AND;
  endfunction
endpackage

// File: rtl/ring_term_slice.sv
// ring_term_slice: evaluates CHUNK ring terms starting at base; out-of-range lanes read 0.
module ring_term_slice
  import ring_gate_pkg::*;
#(
  parameter int N = 130,
  parameter int CHUNK = 16,
  localparam int BW = $clog2(N + CHUNK + 1)
) (
  input  logic [N-1:0]     a,
  input  logic [BW-1:0]    base,
  output logic [CHUNK-1:0] terms,
  output logic [CHUNK-1:0] mask
);
  localparam int IW = $clog2(N);
  always_comb begin
    terms = '0;
    mask = '0;
    for (int k = 0; k < CHUNK; k++) begin
      automatic int idx = int'(base) + k;
      automatic logic [IW-1:0] ix = IW'(idx < N ? idx : 0);
      automatic logic [IW-1:0] nx = IW'(idx >= N - 1 ? 0 : idx + 1);
      automatic kind_e kd = term_kind(idx);
      mask[k] = idx < N;
      terms[k] = mask[k] & (kd == K_AND ? a[ix] & a[nx] : kd == K_NOT ? ~a[ix] : a[ix] | a[nx]);
    end
  end
endmodule

// File: rtl/ring_gate_reducer_seq.sv
// ring_gate_reducer_seq: chunked sequential evaluation and reduction of an N-term ring of gates.
module ring_gate_reducer_seq
  import ring_gate_pkg::*;
#(
  parameter int N = 130,
  parameter int CHUNK = 16,
  localparam int CW = $clog2(N + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  a,
  input  logic [1:0]    mode,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          f,
  output logic [CW-1:0] term_count
);
  localparam int BW = $clog2(N + CHUNK + 1);
  state_e state, state_n;
  mode_e mode_q;
  logic [N-1:0] a_q;
  logic [BW-1:0] base;
  logic [CHUNK-1:0] terms, mask;
  logic [CW-1:0] count, chunk_ones, count_n;
  logic acc, acc_n, last;
  ring_term_slice #(.N(N), .CHUNK(CHUNK)) u_slice (.a(a_q), .base(base), .terms(terms), .mask(mask));
  assign in_ready = state == IDLE;
  assign out_valid = state == DONE;
  always_comb begin
    chunk_ones = '0;
    for (int k = 0; k < CHUNK; k++) chunk_ones = chunk_ones + CW'(terms[k]);
    count_n = count + chunk_ones;
    // masked lanes are 0, so AND must treat them as the identity
    acc_n = mode_q == MODE_AND ? acc & (&(terms | ~mask)) : mode_q == MODE_XOR ? acc ^ (^terms) : acc | (|terms);
    last = int'(base) + CHUNK >= N;
    state_n = state == IDLE ? (in_valid ? BUSY : IDLE) : state == BUSY ? (last ? DONE : BUSY) : (out_ready ? IDLE : DONE);
  end
  always_ff @(posedge clk) state <= rst ? IDLE : state_n;
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q <= '0;
      mode_q <= MODE_OR;
      base <= '0;
      acc <= 1'b0;
      count <= '0;
      f <= 1'b0;
      term_count <= '0;
    end else if (state == IDLE && in_valid) begin
      a_q <= a;
      mode_q <= mode == 2'b11 ? MODE_OR : mode_e'(mode);
      base <= '0;
      acc <= mode_identity(mode);
      count <= '0;
    end else if (state == BUSY) begin
      base <= base + BW'(CHUNK);
      acc <= acc_n;
      count <= count_n;
      if (last) begin
        f <= acc_n;
        term_count <= count_n;
      end
    end
  end
endmodule
